// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner.
// Holds the blank code, the scan state encoding and the digit-index width helper.
// Imported by display_scan_ctrl and scan_timebase.
package display_pkg;

  // Decoder input code that turns every segment off.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Width of a digit index; at least one bit so a single-digit build still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_timebase.sv
// Slot counter and digit index for the display scan, with strobes that fire one cycle ahead.
// Latency: strobes are decoded combinationally from the registered counters.
// Backpressure: none; the timebase is free-running.
module scan_timebase
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD_CYC  = 500
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic [idx_width(NUM_DIGITS)-1:0]  digit_idx,
  output logic                              slot_start,  // first guard cycle of a slot
  output logic                              sample_pt,   // slot_cnt == 1: sample display controls
  output logic                              show_start,  // last guard cycle; SHOW begins next cycle
  output logic                              slot_end,    // last SHOW cycle of the slot
  output logic                              frame_end    // cycle before the last SHOW cycle of the last digit
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] slot_cnt;

  // Count cycles within a slot and advance the digit at each slot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_cnt == CW'(SCAN_DIV - 1)) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx + IW'(1);
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  // Strobes are one cycle early where the top registers an output from them.
  assign slot_start = (slot_cnt == '0);
  assign sample_pt  = (slot_cnt == CW'(1));
  assign show_start = (slot_cnt == CW'(GUARD_CYC - 1));
  assign slot_end   = (slot_cnt == CW'(SCAN_DIV - 1));
  assign frame_end  = (slot_cnt == CW'(SCAN_DIV - 2)) && (digit_idx == IW'(NUM_DIGITS - 1));

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexes one BCD-to-7-segment decoder over NUM_DIGITS anodes with guard, blink, blank and LZ suppression.
// Latency: digits snapshotted at frame start; bcd_out valid from first SHOW cycle; inputs visible within one frame.
// Backpressure: none; scanning is free-running and all outputs are registered.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYC    = 500,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [4*NUM_DIGITS-1:0]           digits,
  input  logic [NUM_DIGITS-1:0]             blink_mask,
  input  logic                              blank_all,
  input  logic                              lz_blank,
  output logic [3:0]                        bcd_out,
  output logic [NUM_DIGITS-1:0]             anode_n,
  output logic [idx_width(NUM_DIGITS)-1:0]  digit_idx,
  output logic                              frame_done
);

  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic slot_start, sample_pt, show_start, slot_end, frame_end;

  scan_state_t                  state;
  logic [NUM_DIGITS-1:0][3:0]   snapshot;
  logic                         blink_phase;
  logic [BW-1:0]                blink_cnt;
  logic                         blank_q;

  logic [NUM_DIGITS-1:0]        lz_vec;
  logic                         lz_run;
  logic                         blank_now;
  logic                         blank_eff;

  scan_timebase #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .GUARD_CYC  (GUARD_CYC)
  ) u_timebase (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_idx  (digit_idx),
    .slot_start (slot_start),
    .sample_pt  (sample_pt),
    .show_start (show_start),
    .slot_end   (slot_end),
    .frame_end  (frame_end)
  );

  // lz_vec[i] = snapshot digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    lz_vec = '0;
    lz_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run    = lz_run & (snapshot[k] == 4'd0);
      lz_vec[k] = lz_run;
    end
  end

  // Blank decision for the current digit; held after the sample point so late control edges cannot glitch SHOW.
  always_comb begin
    blank_now = blank_all
              | (blink_mask[digit_idx] & blink_phase)
              | (lz_blank & (digit_idx != '0) & lz_vec[digit_idx]);
    blank_eff = sample_pt ? blank_now : blank_q;
  end

  // Scan FSM with registered anode, code, frame pulse, snapshot and blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= GUARD;
      anode_n     <= '1;
      bcd_out     <= BLANK_CODE;
      frame_done  <= 1'b0;
      blink_phase <= 1'b0;
      blink_cnt   <= '0;
      blank_q     <= 1'b0;
      snapshot    <= {NUM_DIGITS{BLANK_CODE}};
    end else begin
      // Whole-frame snapshot keeps a half-updated time value off the display.
      if (slot_start && (digit_idx == '0)) begin
        snapshot <= digits;
      end

      if (sample_pt) begin
        bcd_out <= blank_now ? BLANK_CODE : snapshot[digit_idx];
        blank_q <= blank_now;
      end

      case (state)
        GUARD: begin
          if (show_start) begin
            state   <= SHOW;
            anode_n <= blank_eff ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
          end
        end
        SHOW: begin
          if (slot_end) begin
            state   <= GUARD;
            anode_n <= '1;
          end
        end
        default: begin
          state   <= GUARD;
          anode_n <= '1;
        end
      endcase

      frame_done <= frame_end;

      if (frame_done) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: stimulus pushes per-slot expectations from a frame-level model,
// a monitor pops and compares them against the outputs during each SHOW window.
module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int GC = 2;
  localparam int BF = 2;
  localparam int FR = ND * SD;
  localparam int NDIR = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic        blank_all;
  logic        lz_blank;
  logic [3:0]  bcd_out;
  logic [3:0]  anode_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .GUARD_CYC    (GC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .blink_mask (blink_mask),
    .blank_all  (blank_all),
    .lz_blank   (lz_blank),
    .bcd_out    (bcd_out),
    .anode_n    (anode_n),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  // Cycle count since reset release; cycle 0 is the first cycle after release.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [3:0] bcd;
    logic [3:0] an;
  } exp_t;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  m;
    bit          ba;
    bit          lz;
  } fr_t;

  exp_t sb[$];
  exp_t cur;
  fr_t  dir[NDIR];

  int checks = 0;
  int errors = 0;
  bit mon_on = 0;
  int gfr    = 0;
  logic [15:0] msnap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: frame_done and digit index follow from cycle arithmetic; SHOW windows consume scoreboard entries.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on && rst_n) begin
        int s;
        s = cyc % SD;
        check("frame_done", frame_done, (cyc % FR) == FR - 1);
        check("digit_idx", digit_idx, (cyc / SD) % ND);
        if (s < GC) begin
          check("guard_anode", anode_n, 4'hF);
        end else begin
          if (s == GC) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_empty at cyc %0d: got no expectation, required one", cyc);
              cur = '{bcd: 4'hF, an: 4'hF};
            end else begin
              cur = sb.pop_front();
            end
          end
          check("show_anode", anode_n, cur.an);
          check("show_bcd", bcd_out, cur.bcd);
        end
      end
    end
  end

  // Drive inputs for the current cycle and push the slot expectation at the control sample point.
  task automatic step();
    int s = cyc % SD;
    if (cyc % FR == 0) begin
      if (gfr < NDIR) begin
        digits     = dir[gfr].d;
        blink_mask = dir[gfr].m;
        blank_all  = dir[gfr].ba;
        lz_blank   = dir[gfr].lz;
      end else begin
        for (int j = 0; j < ND; j++)
          digits[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        blink_mask = 4'($urandom);
        blank_all  = ($urandom_range(0, 7) == 0);
        lz_blank   = 1'($urandom);
      end
      msnap = digits;
      gfr++;
    end else if (gfr > NDIR) begin
      if ($urandom_range(0, 5) == 0)  digits     = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz_blank   = ~lz_blank;
      if ($urandom_range(0, 31) == 0) blank_all  = ($urandom_range(0, 3) == 0);
    end
    if (gfr == 1 && cyc == 10) digits = 16'h5678;

    if (s == 1) begin
      int   i   = (cyc / SD) % ND;
      bit   ph  = ((cyc / FR) / BF) % 2 == 1;
      bit   zab = 1'b1;
      bit   blk;
      exp_t e;
      for (int j = i; j < ND; j++)
        if (msnap[4*j +: 4] != 4'd0) zab = 1'b0;
      blk   = blank_all || (blink_mask[i] && ph) || (lz_blank && i > 0 && zab);
      e.bcd = blk ? 4'hF : msnap[4*i +: 4];
      e.an  = blk ? 4'hF : ~(4'b0001 << i);
      sb.push_back(e);
    end
  endtask

  initial begin
    dir[0] = '{d: 16'h1234, m: 4'b0000, ba: 1'b0, lz: 1'b0};
    dir[1] = '{d: 16'h5678, m: 4'b0000, ba: 1'b0, lz: 1'b0};
    dir[2] = '{d: 16'h0070, m: 4'b0000, ba: 1'b0, lz: 1'b1};
    dir[3] = '{d: 16'h0000, m: 4'b0000, ba: 1'b0, lz: 1'b1};
    dir[4] = '{d: 16'h1234, m: 4'b0011, ba: 1'b0, lz: 1'b0};
    dir[5] = '{d: 16'h1234, m: 4'b0011, ba: 1'b0, lz: 1'b0};
    dir[6] = '{d: 16'h1234, m: 4'b0011, ba: 1'b0, lz: 1'b0};
    dir[7] = '{d: 16'h1234, m: 4'b0011, ba: 1'b0, lz: 1'b0};
    dir[8] = '{d: 16'h4321, m: 4'b0000, ba: 1'b1, lz: 1'b0};
    dir[9] = '{d: 16'h00A0, m: 4'b0000, ba: 1'b0, lz: 1'b0};

    rst_n      = 1'b0;
    digits     = 16'h1234;
    blink_mask = 4'b0000;
    blank_all  = 1'b0;
    lz_blank   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_anode", anode_n, 4'hF);
    check("rst_bcd", bcd_out, 4'hF);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_digit_idx", digit_idx, 2'd0);

    #2 rst_n = 1'b1;
    mon_on = 1'b1;
    step();
    repeat (30 * FR - 1) begin
      @(negedge clk);
      step();
    end

    // Advance into the SHOW window of digit 2, then reset mid-slot.
    do begin
      @(negedge clk);
      step();
    end while (cyc % FR != 2 * SD + 3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_anode", anode_n, 4'hF);
    check("midrst_bcd", bcd_out, 4'hF);
    check("midrst_digit_idx", digit_idx, 2'd0);
    check("midrst_frame_done", frame_done, 1'b0);
    sb.delete();
    @(negedge clk);
    check("midrst_hold_anode", anode_n, 4'hF);
    #2 rst_n = 1'b1;
    step();
    repeat (4 * FR - 1) begin
      @(negedge clk);
      step();
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
